host_mem_responder: RTL and testbench



---
 rtl/host_mem_responder.sv | 153 +++++++++++++++
 tb/tb_host_mem_responder.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/host_mem_responder.sv
// Host-side responder for AFU read/write request channels: a line-addressed RAM
// behind two in-order request FIFOs with fixed minimum response latency.
module host_mem_responder #(
  parameter int unsigned MEM_AW     = 10,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned AF_THRESH  = 12,
  parameter int unsigned RSP_LAT    = 4
) (
  input  logic         clk,
  input  logic         spl_reset,
  input  logic         afu_tx_rd_valid,
  input  logic [57:0]  afu_tx_rd_addr,
  input  logic [15:0]  afu_tx_rd_mdata,
  output logic         spl_tx_rd_almostfull,
  input  logic         afu_tx_wr_valid,
  input  logic [57:0]  afu_tx_wr_addr,
  input  logic [15:0]  afu_tx_wr_mdata,
  input  logic [511:0] afu_tx_data,
  output logic         spl_tx_wr_almostfull,
  output logic         spl_rx_rd_valid,
  output logic [15:0]  spl_rx_rd_mdata,
  output logic [511:0] spl_rx_data,
  output logic         spl_rx_wr_valid,
  output logic [15:0]  spl_rx_wr_mdata,
  input  logic         rsp_stall,
  output logic         err_overflow
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(FIFO_DEPTH);
  localparam logic [7:0]  LAT8     = 8'(RSP_LAT);

  logic [511:0]      ram [0:(1<<MEM_AW)-1];
  logic [MEM_AW-1:0] rd_addr_mem [0:FIFO_DEPTH-1];
  logic [15:0]       rd_md_mem   [0:FIFO_DEPTH-1];
  logic [7:0]        rd_ts_mem   [0:FIFO_DEPTH-1];
  logic [15:0]       wr_md_mem   [0:FIFO_DEPTH-1];
  logic [7:0]        wr_ts_mem   [0:FIFO_DEPTH-1];

  logic [7:0]   now_q, now_d;
  logic [PW:0]  rd_wp_q, rd_wp_d, rd_rp_q, rd_rp_d;
  logic [PW:0]  wr_wp_q, wr_wp_d, wr_rp_q, wr_rp_d;
  logic         rd_vld_q, rd_vld_d, wr_vld_q, wr_vld_d;
  logic [15:0]  rd_md_q, rd_md_d, wr_md_q, wr_md_d;
  logic [511:0] rd_data_q, rd_data_d;
  logic         rd_af_q, rd_af_d, wr_af_q, wr_af_d;
  logic         err_q, err_d;

  logic [PW:0]   rd_cnt, wr_cnt, rd_cnt_nxt, wr_cnt_nxt;
  logic          rd_full, wr_full, rd_push, wr_push, rd_pop, wr_pop;
  logic [PW-1:0] rd_head, wr_head;
  logic [7:0]    rd_age, wr_age;
  logic          unused_addr_hi;

  always_comb begin
    unused_addr_hi = ^{afu_tx_rd_addr[57:MEM_AW], afu_tx_wr_addr[57:MEM_AW]};

    now_d = now_q + 8'd1;

    rd_cnt  = rd_wp_q - rd_rp_q;
    wr_cnt  = wr_wp_q - wr_rp_q;
    rd_full = (rd_cnt == FULL_CNT);
    wr_full = (wr_cnt == FULL_CNT);
    rd_head = rd_rp_q[PW-1:0];
    wr_head = wr_rp_q[PW-1:0];

    // Fullness is judged before this edge's pop, so a full FIFO rejects even while draining.
    rd_push = afu_tx_rd_valid && !rd_full && !spl_reset;
    wr_push = afu_tx_wr_valid && !wr_full && !spl_reset;

    rd_age = now_q - rd_ts_mem[rd_head];
    wr_age = now_q - wr_ts_mem[wr_head];
    rd_pop = (rd_cnt != '0) && !rsp_stall && (rd_age >= LAT8);
    wr_pop = (wr_cnt != '0) && !rsp_stall && (wr_age >= LAT8);

    rd_wp_d = rd_wp_q + {{PW{1'b0}}, rd_push};
    rd_rp_d = rd_rp_q + {{PW{1'b0}}, rd_pop};
    wr_wp_d = wr_wp_q + {{PW{1'b0}}, wr_push};
    wr_rp_d = wr_rp_q + {{PW{1'b0}}, wr_pop};

    rd_cnt_nxt = rd_wp_d - rd_rp_d;
    wr_cnt_nxt = wr_wp_d - wr_rp_d;
    rd_af_d    = (32'(rd_cnt_nxt) >= AF_THRESH);
    wr_af_d    = (32'(wr_cnt_nxt) >= AF_THRESH);

    // RAM is read combinationally here and written with <= below, giving read-before-write.
    rd_vld_d  = rd_pop;
    rd_md_d   = rd_pop ? rd_md_mem[rd_head] : rd_md_q;
    rd_data_d = rd_pop ? ram[rd_addr_mem[rd_head]] : rd_data_q;
    wr_vld_d  = wr_pop;
    wr_md_d   = wr_pop ? wr_md_mem[wr_head] : wr_md_q;

    err_d = err_q || (afu_tx_rd_valid && rd_full) || (afu_tx_wr_valid && wr_full);
  end

  always_ff @(posedge clk or posedge spl_reset) begin
    if (spl_reset) begin
      now_q     <= '0;
      rd_wp_q   <= '0;
      rd_rp_q   <= '0;
      wr_wp_q   <= '0;
      wr_rp_q   <= '0;
      rd_vld_q  <= 1'b0;
      rd_md_q   <= '0;
      rd_data_q <= '0;
      wr_vld_q  <= 1'b0;
      wr_md_q   <= '0;
      rd_af_q   <= 1'b0;
      wr_af_q   <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      now_q     <= now_d;
      rd_wp_q   <= rd_wp_d;
      rd_rp_q   <= rd_rp_d;
      wr_wp_q   <= wr_wp_d;
      wr_rp_q   <= wr_rp_d;
      rd_vld_q  <= rd_vld_d;
      rd_md_q   <= rd_md_d;
      rd_data_q <= rd_data_d;
      wr_vld_q  <= wr_vld_d;
      wr_md_q   <= wr_md_d;
      rd_af_q   <= rd_af_d;
      wr_af_q   <= wr_af_d;
      err_q     <= err_d;
    end
  end

  // Storage is not reset: stale entries are unreachable once the pointers clear.
  always_ff @(posedge clk) begin
    if (rd_push) begin
      rd_addr_mem[rd_wp_q[PW-1:0]] <= afu_tx_rd_addr[MEM_AW-1:0];
      rd_md_mem[rd_wp_q[PW-1:0]]   <= afu_tx_rd_mdata;
      rd_ts_mem[rd_wp_q[PW-1:0]]   <= now_q;
    end
    if (wr_push) begin
      ram[afu_tx_wr_addr[MEM_AW-1:0]] <= afu_tx_data;
      wr_md_mem[wr_wp_q[PW-1:0]]      <= afu_tx_wr_mdata;
      wr_ts_mem[wr_wp_q[PW-1:0]]      <= now_q;
    end
  end

  always_comb begin
    spl_rx_rd_valid      = rd_vld_q;
    spl_rx_rd_mdata      = rd_md_q;
    spl_rx_data          = rd_data_q;
    spl_rx_wr_valid      = wr_vld_q;
    spl_rx_wr_mdata      = wr_md_q;
    spl_tx_rd_almostfull = rd_af_q;
    spl_tx_wr_almostfull = wr_af_q;
    err_overflow         = err_q;
  end

endmodule

// File: tb/tb_host_mem_responder.sv
// Self-checking bench for host_mem_responder: directed scenarios plus random
// traffic, compared every cycle against a queue-based reference model.
module tb_host_mem_responder;

  localparam int unsigned MEM_AW = 10;
  localparam int unsigned DEPTH  = 16;
  localparam int unsigned AF     = 12;
  localparam int unsigned LAT    = 4;

  logic         clk = 1'b0;
  logic         spl_reset = 1'b0;
  logic         afu_tx_rd_valid, afu_tx_wr_valid, rsp_stall;
  logic [57:0]  afu_tx_rd_addr, afu_tx_wr_addr;
  logic [15:0]  afu_tx_rd_mdata, afu_tx_wr_mdata;
  logic [511:0] afu_tx_data;
  logic         spl_tx_rd_almostfull, spl_tx_wr_almostfull;
  logic         spl_rx_rd_valid, spl_rx_wr_valid, err_overflow;
  logic [15:0]  spl_rx_rd_mdata, spl_rx_wr_mdata;
  logic [511:0] spl_rx_data;

  host_mem_responder #(.MEM_AW(MEM_AW), .FIFO_DEPTH(DEPTH), .AF_THRESH(AF), .RSP_LAT(LAT)) dut (
    .clk(clk), .spl_reset(spl_reset),
    .afu_tx_rd_valid(afu_tx_rd_valid), .afu_tx_rd_addr(afu_tx_rd_addr),
    .afu_tx_rd_mdata(afu_tx_rd_mdata), .spl_tx_rd_almostfull(spl_tx_rd_almostfull),
    .afu_tx_wr_valid(afu_tx_wr_valid), .afu_tx_wr_addr(afu_tx_wr_addr),
    .afu_tx_wr_mdata(afu_tx_wr_mdata), .afu_tx_data(afu_tx_data),
    .spl_tx_wr_almostfull(spl_tx_wr_almostfull),
    .spl_rx_rd_valid(spl_rx_rd_valid), .spl_rx_rd_mdata(spl_rx_rd_mdata),
    .spl_rx_data(spl_rx_data), .spl_rx_wr_valid(spl_rx_wr_valid),
    .spl_rx_wr_mdata(spl_rx_wr_mdata), .rsp_stall(rsp_stall),
    .err_overflow(err_overflow)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int rd_seen = 0;

  typedef struct { int addr; logic [15:0] md; int ts; } rd_ent_t;
  typedef struct { logic [15:0] md; int ts; } wr_ent_t;
  rd_ent_t rq[$];
  wr_ent_t wq[$];
  logic [511:0] mm [0:(1<<MEM_AW)-1];
  int cyc;
  logic e_rv, e_wv, e_raf, e_waf, e_err;
  logic [15:0] e_rmd, e_wmd;
  logic [511:0] e_rdata;

  function automatic logic [511:0] pat(input int i);
    logic [31:0] w;
    w = (32'(i) * 32'h01010101) ^ 32'hDEADBEEF;
    return {16{w}};
  endfunction

  task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    rq.delete();
    wq.delete();
    cyc = 0;
    {e_rv, e_wv, e_raf, e_waf, e_err} = '0;
    e_rmd = '0;
    e_wmd = '0;
    e_rdata = '0;
  endtask

  // One clock edge of the reference: absolute cycle numbers, no wrap.
  task automatic model_edge();
    bit rfull, wfull;
    rd_ent_t rh;
    wr_ent_t wh;
    rfull = (rq.size() == DEPTH);
    wfull = (wq.size() == DEPTH);
    e_rv = 1'b0;
    e_wv = 1'b0;
    if (rq.size() > 0 && !rsp_stall && (cyc - rq[0].ts) >= int'(LAT)) begin
      rh = rq.pop_front();
      e_rv = 1'b1;
      e_rmd = rh.md;
      e_rdata = mm[rh.addr];
    end
    if (wq.size() > 0 && !rsp_stall && (cyc - wq[0].ts) >= int'(LAT)) begin
      wh = wq.pop_front();
      e_wv = 1'b1;
      e_wmd = wh.md;
    end
    if (afu_tx_rd_valid) begin
      if (rfull) e_err = 1'b1;
      else rq.push_back('{addr: int'(afu_tx_rd_addr[MEM_AW-1:0]), md: afu_tx_rd_mdata, ts: cyc});
    end
    if (afu_tx_wr_valid) begin
      if (wfull) e_err = 1'b1;
      else begin
        mm[int'(afu_tx_wr_addr[MEM_AW-1:0])] = afu_tx_data;
        wq.push_back('{md: afu_tx_wr_mdata, ts: cyc});
      end
    end
    e_raf = (rq.size() >= AF);
    e_waf = (wq.size() >= AF);
    cyc++;
  endtask

  task automatic check_outputs();
    chk("rd_valid", spl_rx_rd_valid, e_rv);
    chk("rd_mdata", spl_rx_rd_mdata, e_rmd);
    chk("rd_data", spl_rx_data, e_rdata);
    chk("wr_valid", spl_rx_wr_valid, e_wv);
    chk("wr_mdata", spl_rx_wr_mdata, e_wmd);
    chk("rd_af", spl_tx_rd_almostfull, e_raf);
    chk("wr_af", spl_tx_wr_almostfull, e_waf);
    chk("err", err_overflow, e_err);
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    check_outputs();
    if (spl_rx_rd_valid) rd_seen++;
  endtask

  task automatic clear_inputs();
    afu_tx_rd_valid = 1'b0;
    afu_tx_wr_valid = 1'b0;
    afu_tx_rd_addr = '0;
    afu_tx_wr_addr = '0;
    afu_tx_rd_mdata = '0;
    afu_tx_wr_mdata = '0;
    afu_tx_data = '0;
  endtask

  task automatic idle(input int n);
    clear_inputs();
    repeat (n) step();
  endtask

  task automatic rd(input int addr, input int md);
    afu_tx_rd_valid = 1'b1;
    afu_tx_rd_addr = 58'(addr);
    afu_tx_rd_mdata = 16'(md);
  endtask

  task automatic wr(input int addr, input int md, input logic [511:0] d);
    afu_tx_wr_valid = 1'b1;
    afu_tx_wr_addr = 58'(addr);
    afu_tx_wr_mdata = 16'(md);
    afu_tx_data = d;
  endtask

  task automatic apply_reset(input int n);
    clear_inputs();
    spl_reset = 1'b1;
    model_reset();
    #1;
    check_outputs();
    repeat (n) begin
      @(posedge clk);
      #1;
      check_outputs();
    end
    spl_reset = 1'b0;
  endtask

  initial begin
    logic [511:0] rnd;
    clear_inputs();
    rsp_stall = 1'b0;
    #1;
    apply_reset(3);

    // Preload lines 0..15 with a known pattern.
    for (int i = 0; i < 16; i++) begin
      clear_inputs();
      wr(i, 16'h100 + i, pat(i));
      step();
    end
    idle(8);

    // Write then read, with exact latency checks.
    clear_inputs();
    wr(5, 16'h11, {64{8'hA5}});
    step();
    idle(int'(LAT));
    chk("wtr_wr_valid", spl_rx_wr_valid, 1'b1);
    chk("wtr_wr_mdata", spl_rx_wr_mdata, 16'h11);
    idle(9 - int'(LAT));
    rd(5, 16'h22);
    step();
    idle(int'(LAT));
    chk("wtr_rd_valid", spl_rx_rd_valid, 1'b1);
    chk("wtr_rd_mdata", spl_rx_rd_mdata, 16'h22);
    chk("wtr_rd_data", spl_rx_data, {64{8'hA5}});
    idle(3);

    // Back-to-back reads.
    rd_seen = 0;
    for (int i = 0; i < 8; i++) begin
      clear_inputs();
      rd(i, i);
      step();
    end
    idle(int'(LAT) + 4);
    chk("b2b_count", 32'(rd_seen), 32'd8);

    // Almost-full and overflow under stall.
    rsp_stall = 1'b1;
    for (int i = 0; i < 17; i++) begin
      clear_inputs();
      rd(i, 16'h200 + i);
      step();
      if (i == 10) chk("af_before", spl_tx_rd_almostfull, 1'b0);
      if (i == 11) chk("af_at_thresh", spl_tx_rd_almostfull, 1'b1);
      if (i == 15) chk("no_err_at_full", err_overflow, 1'b0);
      if (i == 16) chk("err_on_17th", err_overflow, 1'b1);
    end
    clear_inputs();
    rd_seen = 0;
    rsp_stall = 1'b0;
    idle(24);
    chk("ovf_count", 32'(rd_seen), 32'd16);

    // Full FIFO with a push presented on its first pop edge.
    rsp_stall = 1'b1;
    for (int i = 0; i < 16; i++) begin
      clear_inputs();
      rd(i, 16'h300 + i);
      step();
    end
    rd_seen = 0;
    rsp_stall = 1'b0;
    clear_inputs();
    rd(7, 16'h3FF);
    step();
    chk("full_pop_valid", spl_rx_rd_valid, 1'b1);
    chk("full_pop_af", spl_tx_rd_almostfull, 1'b1);
    idle(24);
    chk("full_pop_count", 32'(rd_seen), 32'd16);

    // Read pops on the same edge a write to its address is accepted.
    clear_inputs();
    rd(9, 16'h55);
    step();
    idle(int'(LAT) - 1);
    wr(9, 16'h66, '1);
    step();
    chk("rdw_old_valid", spl_rx_rd_valid, 1'b1);
    chk("rdw_old_data", spl_rx_data, pat(9));
    clear_inputs();
    rd(9, 16'h77);
    step();
    idle(int'(LAT));
    chk("rdw_new_data", spl_rx_data, {512{1'b1}});
    idle(4);

    // Random traffic, upper address bits randomised.
    for (int c = 0; c < 400; c++) begin
      clear_inputs();
      rsp_stall = ($urandom_range(0, 9) < 2);
      if ($urandom_range(0, 1) == 1) begin
        afu_tx_rd_valid = 1'b1;
        afu_tx_rd_addr = {26'($urandom), 32'($urandom)};
        afu_tx_rd_addr[MEM_AW-1:0] = MEM_AW'($urandom_range(0, 15));
        afu_tx_rd_mdata = 16'($urandom);
      end
      if ($urandom_range(0, 1) == 1) begin
        for (int k = 0; k < 16; k++) rnd[k*32 +: 32] = $urandom;
        afu_tx_wr_valid = 1'b1;
        afu_tx_wr_addr = {26'($urandom), 32'($urandom)};
        afu_tx_wr_addr[MEM_AW-1:0] = MEM_AW'($urandom_range(0, 15));
        afu_tx_wr_mdata = 16'($urandom);
        afu_tx_data = rnd;
      end
      step();
    end
    rsp_stall = 1'b0;
    idle(30);

    // Reset with reads queued.
    rsp_stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      clear_inputs();
      rd(i, 16'h400 + i);
      step();
    end
    apply_reset(3);
    rsp_stall = 1'b0;
    rd_seen = 0;
    idle(int'(LAT) + 3);
    chk("rst_no_rsp", 32'(rd_seen), 32'd0);
    wr(16'h20, 16'h88, pat(32));
    step();
    idle(2);
    rd(16'h20, 16'h99);
    step();
    idle(int'(LAT));
    chk("post_rst_valid", spl_rx_rd_valid, 1'b1);
    chk("post_rst_mdata", spl_rx_rd_mdata, 16'h99);
    chk("post_rst_data", spl_rx_data, pat(32));
    idle(3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
